// File: rtl/dla_regif_cmdq.sv
// Command queue between the SoC register decoder and the global sequencer.
// Software pushes opcodes into a small FIFO. They are dispatched one at a time
// as single-cycle go pulses, and only while the sequencer reports idle.
module dla_regif_cmdq #(
  parameter int DEPTH    = 8,
  parameter int BUSY_TMO = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmdq_push_wen,
  input  logic        cmdq_ctrl_wen,
  input  logic [31:0] regif_wdata,
  output logic [31:0] cmdq_status_rdata,
  input  logic [31:0] glb_status_rdata,
  output logic        go_mov_ddr2gb,
  output logic        go_mov_gb2lb,
  output logic        go_comp_conv,
  output logic        go_comp_fc,
  output logic        go_comp_ape,
  output logic        go_comp_reshape
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TMO + 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [5:0]    go_q, go_d;
  logic          ill_err_q, ill_err_d;
  logic          ovf_err_q, ovf_err_d;
  logic          tmo_err_q, tmo_err_d;

  logic glb_idle_s, empty_s, full_s, flush_s, clr_s, legal_op_s;
  logic do_push_s, do_pop_s, set_ill_s, set_ovf_s, set_tmo_s;
  logic unused_s;

  assign unused_s   = ^{regif_wdata[29:3], glb_status_rdata[31:6]};
  assign glb_idle_s = (glb_status_rdata[5:0] == 6'd0);
  assign empty_s    = (cnt_q == {CW{1'b0}});
  assign full_s     = (cnt_q == CW'(DEPTH));
  assign flush_s    = cmdq_ctrl_wen & regif_wdata[31];
  assign clr_s      = cmdq_ctrl_wen & regif_wdata[30];
  assign legal_op_s = (regif_wdata[2:0] < 3'd6);

  // A flush in the same cycle discards the push silently (no error flags) and
  // also cancels a pop, so nothing that was queued is dispatched after a flush.
  assign do_pop_s  = (state_q == ST_IDLE) & ~empty_s & glb_idle_s & ~flush_s;
  assign do_push_s = cmdq_push_wen & ~flush_s & legal_op_s & ~full_s;
  assign set_ill_s = cmdq_push_wen & ~flush_s & ~legal_op_s;
  assign set_ovf_s = cmdq_push_wen & ~flush_s & full_s;

  // Dispatch FSM: pop and pulse in IDLE, then wait for busy, then for idle again.
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    go_d      = 6'd0;
    set_tmo_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (do_pop_s) begin
          state_d = ST_ISSUE;
          go_d    = 6'd1 << mem_q[rd_ptr_q];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        tmo_d   = TW'(BUSY_TMO);
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!glb_idle_s) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_q == TW'(1)) begin
          set_tmo_s = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (glb_idle_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO pointer/count and sticky error flag next-state; error clear beats set.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_s) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      cnt_d    = {CW{1'b0}};
    end else begin
      wr_ptr_d = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      cnt_d    = cnt_q + CW'(do_push_s) - CW'(do_pop_s);
    end
    if (clr_s) begin
      ill_err_d = 1'b0;
      ovf_err_d = 1'b0;
      tmo_err_d = 1'b0;
    end else begin
      ill_err_d = ill_err_q | set_ill_s;
      ovf_err_d = ovf_err_q | set_ovf_s;
      tmo_err_d = tmo_err_q | set_tmo_s;
    end
  end

  // Control/state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      cnt_q     <= {CW{1'b0}};
      state_q   <= ST_IDLE;
      tmo_q     <= {TW{1'b0}};
      go_q      <= 6'd0;
      ill_err_q <= 1'b0;
      ovf_err_q <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      go_q      <= go_d;
      ill_err_q <= ill_err_d;
      ovf_err_q <= ovf_err_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  // Opcode storage; contents are only meaningful under the count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= regif_wdata[2:0];
    end
  end

  assign go_mov_ddr2gb   = go_q[0];
  assign go_mov_gb2lb    = go_q[1];
  assign go_comp_conv    = go_q[2];
  assign go_comp_fc      = go_q[3];
  assign go_comp_ape     = go_q[4];
  assign go_comp_reshape = go_q[5];

  assign cmdq_status_rdata = {13'd0, tmo_err_q, ovf_err_q, ill_err_q, 4'd0,
                              state_q, full_s, empty_s, 3'd0, 5'(cnt_q)};

endmodule
